// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC round-robin scheduler: default widths, the
// {valid,id} tag carried alongside each angle, and a one-hot decoder.
package cordic_pkg;

  localparam int ANGLE_W_DEF = 17;
  localparam int DATA_W_DEF  = 16;
  localparam int MAX_N_REQ   = 16;
  localparam int TAG_ID_W    = $clog2(MAX_N_REQ);

  // Sized for the largest supported requester count; smaller configs use the low bits.
  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic logic [MAX_N_REQ-1:0] onehot(input logic [TAG_ID_W-1:0] id);
    return MAX_N_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/cordic_tag_pipe.sv
// Fixed-depth {valid,id} delay line that tracks requests through the
// stall-free CORDIC core pipeline.
module cordic_tag_pipe
  import cordic_pkg::*;
#(
  parameter int DEPTH = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // NOTE: every stage is reset so a reset mid-flight can never release a stale
  // valid tag; sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end sharing one pipelined CORDIC core among N_REQ
// requesters; results are steered back using a latency-matched tag line.
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int LATENCY = 16,
  parameter  int ANGLE_W = ANGLE_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int CNT_W   = $clog2(LATENCY + 2) + 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ANGLE_W-1:0] req_angle,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     hold,
  output logic [ANGLE_W-1:0]       cordic_angle,
  input  logic [DATA_W-1:0]        cordic_cos,
  input  logic [DATA_W-1:0]        cordic_sin,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_cos,
  output logic [DATA_W-1:0]        rsp_sin,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         inflight
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  tag_t               issue_q, issue_d;
  tag_t               ret_tag;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_cos_q, rsp_cos_d;
  logic [DATA_W-1:0]  rsp_sin_q, rsp_sin_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    gnt_id;
  logic               found;
  int                 idx;

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && !hold && Reset && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d   = ptr_q;
    angle_d = angle_q;
    if (found) begin
      ptr_d   = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
      angle_d = req_angle[int'(gnt_id)*ANGLE_W +: ANGLE_W];
    end
    issue_d = '{vld: found, id: TAG_ID_W'(gnt_id)};
  end

  // The issue register is stage 0; the pipe adds LATENCY+1 more to line up with the core.
  cordic_tag_pipe #(
    .DEPTH (LATENCY + 1)
  ) u_tag_pipe (
    .clk     (Clk),
    .rst_n   (Reset),
    .tag_in  (issue_q),
    .tag_out (ret_tag)
  );

  always_comb begin
    rsp_valid_d = '0;
    rsp_cos_d   = rsp_cos_q;
    rsp_sin_d   = rsp_sin_q;
    rsp_id_d    = rsp_id_q;
    if (ret_tag.vld) begin
      rsp_valid_d = N_REQ'(onehot(ret_tag.id));
      rsp_cos_d   = cordic_cos;
      rsp_sin_d   = cordic_sin;
      rsp_id_d    = ID_W'(ret_tag.id);
    end
    inflight_d = inflight_q + CNT_W'(found) - CNT_W'(ret_tag.vld);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr_q       <= '0;
      angle_q     <= '0;
      issue_q     <= '0;
      rsp_valid_q <= '0;
      rsp_cos_q   <= '0;
      rsp_sin_q   <= '0;
      rsp_id_q    <= '0;
      inflight_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      angle_q     <= angle_d;
      issue_q     <= issue_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cos_q   <= rsp_cos_d;
      rsp_sin_q   <= rsp_sin_d;
      rsp_id_q    <= rsp_id_d;
      inflight_q  <= inflight_d;
    end
  end

  assign cordic_angle = angle_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_cos      = rsp_cos_q;
  assign rsp_sin      = rsp_sin_q;
  assign rsp_id       = rsp_id_q;
  assign inflight     = inflight_q;
  assign busy         = (inflight_q != '0);

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Directed bench for cordic_rr_scheduler with a behavioural stand-in for the
// CORDIC core and an issue-order scoreboard for returned results.
module tb_cordic_rr_scheduler;

  localparam int N_REQ   = 4;
  localparam int LATENCY = 16;
  localparam int ANGLE_W = 17;
  localparam int DATA_W  = 16;
  localparam int ID_W    = 2;
  localparam int CNT_W   = $clog2(LATENCY + 2) + 1;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*ANGLE_W-1:0] req_angle;
  logic [N_REQ-1:0]         req_ready;
  logic                     hold;
  logic [ANGLE_W-1:0]       cordic_angle;
  logic [DATA_W-1:0]        cordic_cos;
  logic [DATA_W-1:0]        cordic_sin;
  logic [N_REQ-1:0]         rsp_valid;
  logic [DATA_W-1:0]        rsp_cos;
  logic [DATA_W-1:0]        rsp_sin;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;
  logic [CNT_W-1:0]         inflight;

  cordic_rr_scheduler #(
    .N_REQ   (N_REQ),
    .LATENCY (LATENCY),
    .ANGLE_W (ANGLE_W),
    .DATA_W  (DATA_W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_angle    (req_angle),
    .req_ready    (req_ready),
    .hold         (hold),
    .cordic_angle (cordic_angle),
    .cordic_cos   (cordic_cos),
    .cordic_sin   (cordic_sin),
    .rsp_valid    (rsp_valid),
    .rsp_cos      (rsp_cos),
    .rsp_sin      (rsp_sin),
    .rsp_id       (rsp_id),
    .busy         (busy),
    .inflight     (inflight)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_cos(input logic [ANGLE_W-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [DATA_W-1:0] model_sin(input logic [ANGLE_W-1:0] a);
    return a[16:1] + 16'h0011;
  endfunction

  function automatic logic [ANGLE_W-1:0] ang(input int i, input int s);
    return ANGLE_W'(32'h3C00 + i * 32'h200 + s * 32'h1000);
  endfunction

  // Core stand-in: result reflects cordic_angle captured LATENCY+1 edges earlier.
  logic [ANGLE_W-1:0] core_q [LATENCY+1];
  always @(posedge Clk) begin
    core_q[0] <= cordic_angle;
    for (int k = 1; k <= LATENCY; k++) core_q[k] <= core_q[k-1];
  end
  assign cordic_cos = model_cos(core_q[LATENCY]);
  assign cordic_sin = model_sin(core_q[LATENCY]);

  typedef struct {
    int                 id;
    logic [ANGLE_W-1:0] a;
    int                 t;
  } iss_t;

  iss_t iss_q [$];
  int   cyc = 0;

  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) iss_q.push_back('{i, req_angle[i*ANGLE_W +: ANGLE_W], cyc});
      end
    end
  end

  always @(negedge Reset) iss_q.delete();

  always @(negedge Clk) begin
    if (Reset && rsp_valid != '0) begin
      if (iss_q.size() == 0) begin
        check("rsp_spurious", 32'(rsp_valid), 32'd0);
      end else begin
        iss_t e;
        e = iss_q.pop_front();
        check("rsp_onehot", 32'(rsp_valid), 32'(1) << e.id);
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_cos", 32'(rsp_cos), 32'(model_cos(e.a)));
        check("rsp_sin", 32'(rsp_sin), 32'(model_sin(e.a)));
        check("rsp_latency", 32'(cyc - e.t), 32'(LATENCY + 2));
      end
    end
  end

  int peak = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
    if (int'(inflight) > peak) peak = int'(inflight);
  endtask

  task automatic set_angles(input int s);
    for (int i = 0; i < N_REQ; i++) req_angle[i*ANGLE_W +: ANGLE_W] = ang(i, s);
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < max);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] t3_v [6] = '{4'b0010, 4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
  logic [3:0] t3_e [6] = '{4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
  logic [3:0] t4_e [7] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int n;
    bit seen;
    int cnt;

    Reset     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    set_angles(0);
    repeat (3) @(posedge Clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_cos", 32'(rsp_cos), 32'd0);
    check("rst_rsp_sin", 32'(rsp_sin), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_angle", 32'(cordic_angle), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    req_valid = 4'hF;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    Reset     = 1'b1;
    tick();
    tick();

    // Single request from requester 2.
    req_valid = 4'b0100;
    #1;
    check("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    check("t1_angle", 32'(cordic_angle), 32'h04000);
    check("t1_inflight1", 32'(inflight), 32'd1);
    check("t1_busy1", 32'(busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (rsp_valid != '0) seen = 1'b1;
    end
    check("t1_latency", 32'(n), 32'd18);
    check("t1_rsp_valid", 32'(rsp_valid), 32'b0100);
    check("t1_rsp_id", 32'(rsp_id), 32'd2);
    check("t1_rsp_cos", 32'(rsp_cos), 32'h1A5A);
    check("t1_rsp_sin", 32'(rsp_sin), 32'h2011);
    check("t1_inflight0", 32'(inflight), 32'd0);
    check("t1_busy0", 32'(busy), 32'd0);
    tick();
    check("t1_strobe", 32'(rsp_valid), 32'd0);

    // All four continuously from a fresh reset.
    Reset = 1'b0;
    tick();
    Reset     = 1'b1;
    peak      = 0;
    req_valid = 4'hF;
    for (int i = 0; i < 24; i++) begin
      set_angles(i + 1);
      #1;
      check("t2_grant", 32'(req_ready), 32'(1) << (i % 4));
      tick();
    end
    req_valid = '0;
    wait_idle(60, n);
    check("t2_peak", 32'(peak), 32'd18);
    check("t2_idle", 32'(busy), 32'd0);

    // Requester 1 continuous, requester 3 joins.
    for (int i = 0; i < 6; i++) begin
      req_valid = t3_v[i];
      set_angles(30 + i);
      #1;
      check("t3_grant", 32'(req_ready), 32'(t3_e[i]));
      tick();
    end
    req_valid = '0;
    wait_idle(60, n);

    // Back-to-back traffic interrupted by hold.
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      set_angles(40 + i);
      #1;
      check("t4_grant_pre", 32'(req_ready), 32'(t4_e[i]));
      tick();
    end
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    hold = 1'b0;
    for (int i = 4; i < 7; i++) begin
      set_angles(40 + i);
      #1;
      check("t4_grant_post", 32'(req_ready), 32'(t4_e[i]));
      tick();
    end
    req_valid = '0;
    wait_idle(60, n);
    check("t4_busy_drop", 32'(n), 32'd18);

    // Reset while eight requests are in flight.
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      set_angles(50 + i);
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
    check("t5_pre_inflight", 32'(inflight), 32'd8);
    #2;
    Reset = 1'b0;
    #1;
    check("t5_async_inflight", 32'(inflight), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_angle", 32'(cordic_angle), 32'd0);
    check("t5_async_cos", 32'(rsp_cos), 32'd0);
    check("t5_async_valid", 32'(rsp_valid), 32'd0);
    tick();
    Reset = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid != '0) cnt++;
    end
    check("t5_no_rsp", 32'(cnt), 32'd0);
    req_valid = 4'hF;
    #1;
    check("t5_first_grant", 32'(req_ready), 32'b0001);

    // Grant and response on the same edge.
    req_valid = 4'b0001;
    set_angles(60);
    tick();
    req_valid = '0;
    repeat (LATENCY + 1) tick();
    set_angles(61);
    req_valid = 4'b0010;
    #1;
    check("t6_ready", 32'(req_ready), 32'b0010);
    check("t6_inflight_pre", 32'(inflight), 32'd1);
    tick();
    req_valid = '0;
    check("t6_inflight_same", 32'(inflight), 32'd1);
    check("t6_rsp_valid", 32'(rsp_valid), 32'b0001);
    check("t6_rsp_id", 32'(rsp_id), 32'd0);
    check("t6_rsp_cos", 32'(rsp_cos), 32'(model_cos(ang(0, 60))));
    check("t6_angle", 32'(cordic_angle), 32'(ang(1, 61)));
    wait_idle(60, n);
    check("t6_idle", 32'(busy), 32'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
